// File: rtl/vanilla_instr_encoder.sv
// vanilla_instr_encoder
//   Turns compact instruction commands into RV32 machine words for the vanilla
//   core decoder (tile bring-up, test sequencers, remote instruction loading).
//   The LI pseudo-op expands into one or two words; every other legal command
//   becomes exactly one word. Both sides use valid/ready handshakes, so a
//   two-word expansion can be held off by the consumer.
//
// Ports
//   clk_i            clock
//   reset_n_i        asynchronous active-low reset
//   v_i / ready_o    command handshake (accepted when v_i & ready_o)
//   cmd_i            command code (0..9 legal, 10..15 illegal)
//   rd_i/rs1_i/rs2_i register indices
//   imm_i            immediate; CSR address in [11:0]
//   v_o / yumi_i     instruction word handshake (yumi_i only legal with v_o)
//   instr_o          registered instruction word
//   last_o           final word of the current command's expansion
//   illegal_o        one-cycle pulse after an unsupported command is accepted
//   emitted_count_o  words consumed, wraps modulo 2^cnt_width_p
module vanilla_instr_encoder #(
   parameter int unsigned cnt_width_p = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   v_i,
   output logic                   ready_o,
   input  logic [3:0]             cmd_i,
   input  logic [4:0]             rd_i,
   input  logic [4:0]             rs1_i,
   input  logic [4:0]             rs2_i,
   input  logic [31:0]            imm_i,
   output logic                   v_o,
   output logic [31:0]            instr_o,
   output logic                   last_o,
   input  logic                   yumi_i,
   output logic                   illegal_o,
   output logic [cnt_width_p-1:0] emitted_count_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_HOLD  = 2'd1,
      ST_HOLD2 = 2'd2
   } state_e;

   typedef enum logic [3:0] {
      CMD_NOP     = 4'd0,
      CMD_ADDI    = 4'd1,
      CMD_ADD     = 4'd2,
      CMD_LW      = 4'd3,
      CMD_SW      = 4'd4,
      CMD_LI      = 4'd5,
      CMD_FENCE   = 4'd6,
      CMD_CSRRW   = 4'd7,
      CMD_MUL     = 4'd8,
      CMD_AMOSWAP = 4'd9
   } cmd_e;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_SYS = 7'b1110011;
   localparam logic [6:0] OP_AMO = 7'b0101111;

   state_e                 state_q, state_d;
   logic [31:0]            instr_q, instr_d;
   logic [31:0]            pend_q,  pend_d;
   logic                   illegal_q, illegal_d;
   logic [cnt_width_p-1:0] count_q, count_d;

   // Encoder outputs for the command currently on the input port.
   logic [31:0] enc_w0, enc_w1;
   logic        enc_two;
   logic        enc_ill;

   logic [11:0] imm12;
   logic        li_fits;
   logic [31:0] li_round;
   logic        accept;
   logic        take;

   assign imm12    = imm_i[11:0];
   assign li_fits  = (imm_i == {{20{imm12[11]}}, imm12});
   // Adding 0x800 pre-compensates for the sign-extended ADDI that follows the LUI.
   assign li_round = imm_i + 32'h0000_0800;

   always_comb begin
      enc_w0  = 32'h0000_0013;
      enc_w1  = '0;
      enc_two = 1'b0;
      enc_ill = 1'b0;
      unique case (cmd_i)
         CMD_NOP:     enc_w0 = 32'h0000_0013;
         CMD_ADDI:    enc_w0 = {imm12, rs1_i, 3'b000, rd_i, OP_IMM};
         CMD_ADD:     enc_w0 = {7'b0000000, rs2_i, rs1_i, 3'b000, rd_i, OP_REG};
         CMD_LW:      enc_w0 = {imm12, rs1_i, 3'b010, rd_i, OP_LD};
         CMD_SW:      enc_w0 = {imm12[11:5], rs2_i, rs1_i, 3'b010, imm12[4:0], OP_ST};
         CMD_LI: begin
            if (li_fits) begin
               enc_w0 = {imm12, 5'd0, 3'b000, rd_i, OP_IMM};
            end else begin
               enc_w0  = {li_round[31:12], rd_i, OP_LUI};
               enc_w1  = {imm12, rd_i, 3'b000, rd_i, OP_IMM};
               enc_two = (imm12 != 12'd0);
            end
         end
         CMD_FENCE:   enc_w0 = 32'h0FF0_000F;
         CMD_CSRRW:   enc_w0 = {imm12, rs1_i, 3'b001, rd_i, OP_SYS};
         CMD_MUL:     enc_w0 = {7'b0000001, rs2_i, rs1_i, 3'b000, rd_i, OP_REG};
         CMD_AMOSWAP: enc_w0 = {5'b00001, 1'b0, 1'b0, rs2_i, rs1_i, 3'b010, rd_i, OP_AMO};
         default:     enc_ill = 1'b1;
      endcase
   end

   assign v_o             = (state_q != ST_EMPTY);
   assign last_o          = (state_q == ST_HOLD);
   assign ready_o         = (state_q == ST_EMPTY) | ((state_q == ST_HOLD) & yumi_i);
   assign instr_o         = instr_q;
   assign illegal_o       = illegal_q;
   assign emitted_count_o = count_q;

   assign accept = v_i & ready_o;
   // A yumi_i with nothing held is a protocol error and is ignored.
   assign take   = yumi_i & v_o;

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      pend_d    = pend_q;
      illegal_d = 1'b0;
      count_d   = take ? count_q + cnt_width_p'(1) : count_q;

      unique case (state_q)
         ST_EMPTY: ;
         ST_HOLD:  if (take) state_d = ST_EMPTY;
         ST_HOLD2: begin
            if (take) begin
               state_d = ST_HOLD;
               instr_d = pend_q;
            end
         end
         default:  state_d = ST_EMPTY;
      endcase

      // Acceptance is only possible from EMPTY or from HOLD while its word is
      // being taken, so a new command always overrides the drain step above.
      if (accept) begin
         if (enc_ill) begin
            illegal_d = 1'b1;
            state_d   = ST_EMPTY;
         end else begin
            instr_d = enc_w0;
            pend_d  = enc_w1;
            state_d = enc_two ? ST_HOLD2 : ST_HOLD;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= ST_EMPTY;
         instr_q   <= '0;
         pend_q    <= '0;
         illegal_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         pend_q    <= pend_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
      end
   end

endmodule
